// File: rtl/uart_transceiver.sv
// UART with TX/RX FIFOs, runtime baud divisor, parity mode and 1/2 stop bits.
// Define UART_PARITY_EN to honour cfg_parity; otherwise no parity bit is sent or checked.
module uart_transceiver #(
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned SIZE_FIFO = 8,
   parameter int unsigned SAMPLE    = 16,
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] cfg_divisor,
   input  logic [1:0]           cfg_parity,
   input  logic                 cfg_two_stop,
   input  logic                 write_data,
   input  logic [DATA_SIZE-1:0] bus_data_in,
   input  logic                 read_data,
   output logic [DATA_SIZE-1:0] bus_data_out,
   input  logic                 serial_data_in,
   output logic                 serial_data_out,
   output logic [7:0]           TX_status_register,
   output logic [7:0]           RX_status_register
);
   localparam int unsigned AW = $clog2(SIZE_FIFO);
   localparam int unsigned SW = $clog2(SAMPLE);
   localparam logic [SW-1:0] SmpLast = SW'(SAMPLE - 1);
   localparam logic [SW-1:0] SmpMid  = SW'(SAMPLE / 2 - 1);
   localparam logic [3:0]    BitLast = 4'(DATA_SIZE - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   logic [DIV_WIDTH-1:0] cfg_div_m1;
   logic                 cfg_par_en;
   assign cfg_div_m1 = (cfg_divisor == '0) ? '0 : cfg_divisor - 1'b1;
`ifdef UART_PARITY_EN
   assign cfg_par_en = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
`else
   logic unused_cfg_parity;
   assign cfg_par_en        = 1'b0;
   assign unused_cfg_parity = ^cfg_parity;
`endif

   // ---------------- TX side
   logic [DATA_SIZE-1:0] tx_mem [SIZE_FIFO];
   logic [AW:0]          tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic                 tx_err_q, tx_err_d, tx_empty, tx_full, tx_push, tx_load, tx_bit_end;
   state_e               tx_state_q, tx_state_d;
   logic [DIV_WIDTH-1:0] tx_div_cnt_q, tx_div_cnt_d, tx_divm1_q, tx_divm1_d;
   logic [SW-1:0]        tx_smp_q, tx_smp_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic [DATA_SIZE-1:0] tx_shift_q, tx_shift_d, tx_head;
   logic                 tx_two_q, tx_two_d, tx_par_en_q, tx_par_en_d, tx_line_q, tx_line_d;
`ifdef UART_PARITY_EN
   logic                 tx_par_q, tx_par_d;
`endif

   assign tx_empty   = tx_wptr_q == tx_rptr_q;
   assign tx_full    = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
   assign tx_push    = write_data && !tx_full;
   assign tx_head    = tx_mem[tx_rptr_q[AW-1:0]];
   assign tx_bit_end = (tx_div_cnt_q == tx_divm1_q) && (tx_smp_q == SmpLast);

   always_comb begin
      tx_state_d   = tx_state_q;
      tx_div_cnt_d = tx_div_cnt_q;
      tx_smp_d     = tx_smp_q;
      tx_bit_d     = tx_bit_q;
      tx_shift_d   = tx_shift_q;
      tx_divm1_d   = tx_divm1_q;
      tx_two_d     = tx_two_q;
      tx_par_en_d  = tx_par_en_q;
`ifdef UART_PARITY_EN
      tx_par_d     = tx_par_q;
`endif
      tx_load      = 1'b0;
      if (tx_state_q != StIdle) begin
         if (tx_div_cnt_q == tx_divm1_q) begin
            tx_div_cnt_d = '0;
            tx_smp_d     = (tx_smp_q == SmpLast) ? '0 : tx_smp_q + 1'b1;
         end else begin
            tx_div_cnt_d = tx_div_cnt_q + 1'b1;
         end
      end
      case (tx_state_q)
         StIdle:  tx_load = !tx_empty;
         StStart: if (tx_bit_end) tx_state_d = StData;
         StData: begin
            if (tx_bit_end) begin
               tx_shift_d = tx_shift_q >> 1;
               if (tx_bit_q == BitLast) begin
                  tx_bit_d   = '0;
                  tx_state_d = tx_par_en_q ? StParity : StStop;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
`ifdef UART_PARITY_EN
         StParity: if (tx_bit_end) tx_state_d = StStop;
`endif
         StStop: begin
            // Back-to-back frames: reload straight from STOP with no idle bit.
            if (tx_bit_end) begin
               if (tx_two_q && (tx_bit_q == '0)) tx_bit_d = 4'd1;
               else if (!tx_empty)               tx_load = 1'b1;
               else                              tx_state_d = StIdle;
            end
         end
         default: tx_state_d = StIdle;
      endcase
      if (tx_load) begin
         tx_state_d   = StStart;
         tx_shift_d   = tx_head;
         tx_divm1_d   = cfg_div_m1;
         tx_two_d     = cfg_two_stop;
         tx_par_en_d  = cfg_par_en;
`ifdef UART_PARITY_EN
         tx_par_d     = cfg_parity[1] ^ (^tx_head);
`endif
         tx_div_cnt_d = '0;
         tx_smp_d     = '0;
         tx_bit_d     = '0;
      end
      case (tx_state_d)
         StStart:  tx_line_d = 1'b0;
         StData:   tx_line_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
         StParity: tx_line_d = tx_par_d;
`endif
         default:  tx_line_d = 1'b1;
      endcase
      tx_wptr_d = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
      tx_rptr_d = tx_load ? tx_rptr_q + 1'b1 : tx_rptr_q;
      tx_err_d  = write_data ? tx_full : tx_err_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q   <= StIdle;
         tx_div_cnt_q <= '0;
         tx_smp_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         tx_divm1_q   <= '0;
         tx_two_q     <= 1'b0;
         tx_par_en_q  <= 1'b0;
         tx_line_q    <= 1'b1;
         tx_wptr_q    <= '0;
         tx_rptr_q    <= '0;
         tx_err_q     <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par_q     <= 1'b0;
`endif
      end else begin
         tx_state_q   <= tx_state_d;
         tx_div_cnt_q <= tx_div_cnt_d;
         tx_smp_q     <= tx_smp_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         tx_divm1_q   <= tx_divm1_d;
         tx_two_q     <= tx_two_d;
         tx_par_en_q  <= tx_par_en_d;
         tx_line_q    <= tx_line_d;
         tx_wptr_q    <= tx_wptr_d;
         tx_rptr_q    <= tx_rptr_d;
         tx_err_q     <= tx_err_d;
`ifdef UART_PARITY_EN
         tx_par_q     <= tx_par_d;
`endif
      end
   end

   // ---------------- RX side
   logic [DATA_SIZE-1:0] rx_mem [SIZE_FIFO];
   logic [AW:0]          rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic                 rx_empty, rx_full, rx_push, rx_push_ok, rx_pop, rx_sample;
   logic                 rx_s1_q, rx_s2_q, rx_s3_q, rx_ovf_q, rx_ovf_d, rx_rerr_q, rx_rerr_d;
   logic                 rx_stop_err_q, rx_stop_err_d, rx_brk_err_q, rx_brk_err_d;
   logic                 rx_par_en_q, rx_par_en_d, rx_par_err, rx_frame_par_err, rx_pbit_low;
   state_e               rx_state_q, rx_state_d;
   logic [DIV_WIDTH-1:0] rx_div_cnt_q, rx_div_cnt_d, rx_divm1_q, rx_divm1_d;
   logic [SW-1:0]        rx_smp_q, rx_smp_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic [DATA_SIZE-1:0] rx_shift_q, rx_shift_d;
`ifdef UART_PARITY_EN
   logic                 rx_odd_q, rx_odd_d, rx_pbit_q, rx_pbit_d, rx_par_err_q, rx_par_err_d;
   assign rx_frame_par_err = rx_par_en_q && (^rx_shift_q ^ rx_pbit_q ^ rx_odd_q);
   assign rx_pbit_low      = !(rx_par_en_q && rx_pbit_q);
   assign rx_par_err       = rx_par_err_q;
`else
   assign rx_frame_par_err = 1'b0;
   assign rx_pbit_low      = 1'b1;
   assign rx_par_err       = 1'b0;
`endif

   assign rx_empty   = rx_wptr_q == rx_rptr_q;
   assign rx_full    = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
   assign rx_pop     = read_data && !rx_empty;
   assign rx_push_ok = rx_push && (!rx_full || rx_pop);
   assign rx_sample  = (rx_div_cnt_q == rx_divm1_q) && (rx_smp_q == SmpMid);

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_div_cnt_d  = rx_div_cnt_q;
      rx_smp_d      = rx_smp_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_divm1_d    = rx_divm1_q;
      rx_par_en_d   = rx_par_en_q;
      rx_stop_err_d = rx_stop_err_q;
      rx_brk_err_d  = rx_brk_err_q;
`ifdef UART_PARITY_EN
      rx_odd_d      = rx_odd_q;
      rx_pbit_d     = rx_pbit_q;
      rx_par_err_d  = rx_par_err_q;
`endif
      rx_push       = 1'b0;
      if (rx_state_q != StIdle) begin
         if (rx_div_cnt_q == rx_divm1_q) begin
            rx_div_cnt_d = '0;
            rx_smp_d     = (rx_smp_q == SmpLast) ? '0 : rx_smp_q + 1'b1;
         end else begin
            rx_div_cnt_d = rx_div_cnt_q + 1'b1;
         end
      end
      case (rx_state_q)
         StIdle: begin
            if (!rx_s2_q && rx_s3_q) begin
               rx_state_d   = StStart;
               rx_div_cnt_d = '0;
               rx_smp_d     = '0;
               rx_divm1_d   = cfg_div_m1;
               rx_par_en_d  = cfg_par_en;
`ifdef UART_PARITY_EN
               rx_odd_d     = cfg_parity[1];
`endif
            end
         end
         StStart: begin
            if (rx_sample) begin
               rx_state_d = rx_s2_q ? StIdle : StData;
               rx_bit_d   = '0;
            end
         end
         StData: begin
            if (rx_sample) begin
               rx_shift_d = {rx_s2_q, rx_shift_q[DATA_SIZE-1:1]};
               rx_bit_d   = rx_bit_q + 1'b1;
               if (rx_bit_q == BitLast) rx_state_d = rx_par_en_q ? StParity : StStop;
            end
         end
`ifdef UART_PARITY_EN
         StParity: begin
            if (rx_sample) begin
               rx_pbit_d  = rx_s2_q;
               rx_state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (rx_sample) begin
               rx_push       = 1'b1;
               rx_stop_err_d = !rx_s2_q;
               rx_brk_err_d  = !rx_s2_q && (rx_shift_q == '0) && rx_pbit_low;
`ifdef UART_PARITY_EN
               rx_par_err_d  = rx_frame_par_err;
`endif
               rx_state_d    = StIdle;
            end
         end
         default: rx_state_d = StIdle;
      endcase
      rx_wptr_d = rx_push_ok ? rx_wptr_q + 1'b1 : rx_wptr_q;
      rx_rptr_d = rx_pop ? rx_rptr_q + 1'b1 : rx_rptr_q;
      rx_ovf_d  = rx_push ? !rx_push_ok : rx_ovf_q;
      rx_rerr_d = read_data ? rx_empty : rx_rerr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1_q       <= 1'b1;
         rx_s2_q       <= 1'b1;
         rx_s3_q       <= 1'b1;
         rx_state_q    <= StIdle;
         rx_div_cnt_q  <= '0;
         rx_smp_q      <= '0;
         rx_bit_q      <= '0;
         rx_shift_q    <= '0;
         rx_divm1_q    <= '0;
         rx_par_en_q   <= 1'b0;
         rx_stop_err_q <= 1'b0;
         rx_brk_err_q  <= 1'b0;
         rx_ovf_q      <= 1'b0;
         rx_rerr_q     <= 1'b0;
         rx_wptr_q     <= '0;
         rx_rptr_q     <= '0;
`ifdef UART_PARITY_EN
         rx_odd_q      <= 1'b0;
         rx_pbit_q     <= 1'b0;
         rx_par_err_q  <= 1'b0;
`endif
      end else begin
         rx_s1_q       <= serial_data_in;
         rx_s2_q       <= rx_s1_q;
         rx_s3_q       <= rx_s2_q;
         rx_state_q    <= rx_state_d;
         rx_div_cnt_q  <= rx_div_cnt_d;
         rx_smp_q      <= rx_smp_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         rx_divm1_q    <= rx_divm1_d;
         rx_par_en_q   <= rx_par_en_d;
         rx_stop_err_q <= rx_stop_err_d;
         rx_brk_err_q  <= rx_brk_err_d;
         rx_ovf_q      <= rx_ovf_d;
         rx_rerr_q     <= rx_rerr_d;
         rx_wptr_q     <= rx_wptr_d;
         rx_rptr_q     <= rx_rptr_d;
`ifdef UART_PARITY_EN
         rx_odd_q      <= rx_odd_d;
         rx_pbit_q     <= rx_pbit_d;
         rx_par_err_q  <= rx_par_err_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push)    tx_mem[tx_wptr_q[AW-1:0]] <= bus_data_in;
      if (rx_push_ok) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
   end

   assign serial_data_out    = tx_line_q;
   assign bus_data_out       = rx_empty ? '0 : rx_mem[rx_rptr_q[AW-1:0]];
   assign TX_status_register = {5'b0, tx_empty, tx_full, tx_err_q};
   assign RX_status_register = {rx_state_q != StIdle, rx_ovf_q, rx_stop_err_q, rx_brk_err_q,
                                rx_par_err, rx_empty, rx_full, rx_rerr_q};
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: TX timing, loopback, FIFO flags, RX error reporting.
module tb_uart_transceiver;
   localparam int unsigned DS = 8, SF = 8, SMP = 16, DW = 16;
`ifdef UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic          clk = 1'b0, reset = 1'b1;
   logic [DW-1:0] cfg_divisor = 16'd1;
   logic [1:0]    cfg_parity = 2'b00;
   logic          cfg_two_stop = 1'b0, write_data = 1'b0, read_data = 1'b0;
   logic [DS-1:0] bus_data_in = '0, bus_data_out;
   logic          serial_in, serial_out, loop_en = 1'b0, drv_line = 1'b1;
   logic [7:0]    tx_st, rx_st;
   logic [9:0]    pat;
   int            vectors = 0, miscompares = 0, frame;

   assign serial_in = loop_en ? serial_out : drv_line;
   always #5 clk = ~clk;

   uart_transceiver #(.DATA_SIZE(DS), .SIZE_FIFO(SF), .SAMPLE(SMP), .DIV_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .cfg_divisor(cfg_divisor), .cfg_parity(cfg_parity),
      .cfg_two_stop(cfg_two_stop), .write_data(write_data), .bus_data_in(bus_data_in),
      .read_data(read_data), .bus_data_out(bus_data_out), .serial_data_in(serial_in),
      .serial_data_out(serial_out), .TX_status_register(tx_st), .RX_status_register(rx_st)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      bus_data_in = d;
      write_data  = 1'b1;
      step(1);
      write_data  = 1'b0;
   endtask

   task automatic pop();
      read_data = 1'b1;
      step(1);
      read_data = 1'b0;
   endtask

   task automatic drive_bit(input logic v);
      drv_line = v;
      step(SMP);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (PB == 1) drive_bit(pbit);
      drive_bit(stop);
      drv_line = 1'b1;
      step(2 * SMP);
   endtask

   initial begin
      // Reset values
      step(3);
      check("rst_line", serial_out, 1);
      check("rst_tx_st", tx_st, 8'h04);
      check("rst_rx_st", rx_st, 8'h04);
      check("rst_bus", bus_data_out, 0);
      reset = 1'b0;
      step(1);

      pop();
      check("rd_empty_err", rx_st, 8'h05);
      check("rd_empty_bus", bus_data_out, 0);

      // Single word A5 at D=1, looped back into RX
      loop_en = 1'b1;
      pat     = 10'b1101001010;
      push(8'hA5);
      check("tx_pushed_st", tx_st, 8'h00);
      step(1);
      check("tx_popped_st", tx_st, 8'h04);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < SMP; j++) begin
            if (j == 0 || j == SMP - 1) check($sformatf("a5_bit%0d_%0d", i, j), serial_out, pat[i]);
            if (1 + SMP * i + j == 154) check("rx_empty_early", rx_st[2], 1);
            if (1 + SMP * i + j == 157) check("rx_empty_late", rx_st[2], 0);
            step(1);
         end
      end
      check("a5_idle_line", serial_out, 1);
      check("a5_rx_bus", bus_data_out, 8'hA5);
      check("a5_rx_st", rx_st, 8'h01);
      pop();
      check("a5_rx_st_after", rx_st, 8'h04);

      // Back-to-back with parity request, two stops, divisor 0 (treated as 1)
      cfg_divisor  = '0;
      cfg_parity   = 2'b01;
      cfg_two_stop = 1'b1;
      frame        = (1 + 8 + PB + 2) * SMP;
      push(8'h3C);
      push(8'hFF);
      push(8'h00);
      step(frame - 2);
      check("b2b_stop1", serial_out, 1);
      step(1);
      check("b2b_start2", serial_out, 0);
      step(frame - 1);
      check("b2b_stop2", serial_out, 1);
      step(1);
      check("b2b_start3", serial_out, 0);
      step(frame + 200);
      check("b2b_rx_st", rx_st, 8'h00);
      check("b2b_w0", bus_data_out, 8'h3C);
      pop();
      check("b2b_w1", bus_data_out, 8'hFF);
      pop();
      check("b2b_w2", bus_data_out, 8'h00);
      pop();
      check("b2b_rx_empty", rx_st, 8'h04);

      // RX overflow
      cfg_divisor  = 16'd1;
      cfg_parity   = 2'b00;
      cfg_two_stop = 1'b0;
      for (int i = 1; i <= SF + 1; i++) push(8'(i));
      step(1460);
      check("ovf_st", rx_st, 8'h42);
      check("ovf_w1", bus_data_out, 8'h01);
      pop();
      check("ovf_after_pop", rx_st, 8'h40);
      push(8'h0A);
      step(200);
      check("ovf_cleared", rx_st, 8'h02);
      for (int i = 2; i <= 9; i++) begin
         check($sformatf("ovf_w%0d", i), bus_data_out, (i == 9) ? 8'h0A : 8'(i));
         pop();
      end
      check("ovf_drained", rx_st, 8'h04);

      // Write while full with the engine stuck in a long frame, then reset mid-frame
      cfg_divisor = 16'hFFFF;
      push(8'h11);
      for (int i = 0; i < 9; i++) begin
         push(8'(8'h20 + i));
         if (i == 7) check("wf_full", tx_st, 8'h02);
      end
      check("wf_dropped", tx_st, 8'h03);
      step(3);
      check("wf_held", tx_st, 8'h03);
      check("mid_line", serial_out, 0);
      check("mid_rx_busy", rx_st, 8'h84);
      reset = 1'b1;
      step(1);
      check("mid_rst_line", serial_out, 1);
      check("mid_rst_tx", tx_st, 8'h04);
      check("mid_rst_rx", rx_st, 8'h04);
      reset = 1'b0;
      step(1);

      // Write error held across a pop and cleared by the next accepted write
      loop_en     = 1'b0;
      cfg_divisor = 16'd1;
      push(8'h11);
      for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
      check("we_set", tx_st, 8'h03);
      step(165);
      check("we_held", tx_st, 8'h01);
      push(8'h33);
      check("we_clr", tx_st, 8'h02);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(1);

      // RX errors on a driven line
      cfg_parity = 2'b01;
      drv_line   = 1'b0;
      step(12 * SMP);
      drv_line   = 1'b1;
      step(40);
      check("brk_st", rx_st, 8'h30);
      check("brk_word", bus_data_out, 8'h00);
      pop();
`ifdef UART_PARITY_EN
      send_frame(8'h01, 1'b0, 1'b1);
      check("par_st", rx_st, 8'h08);
`else
      send_frame(8'h01, 1'b0, 1'b0);
      check("stop_st", rx_st, 8'h20);
`endif
      check("err_word", bus_data_out, 8'h01);
      pop();
      send_frame(8'h5A, 1'b0, 1'b1);
      check("good_st", rx_st, 8'h00);
      check("good_word", bus_data_out, 8'h5A);
      pop();
      check("final_rx", rx_st, 8'h04);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
